// File: rtl/multdiv_iterative_unit.sv
// -----------------------------------------------------------------------------
// multdiv_iterative_unit
//
// Iterative signed multiply/divide stage that sits right after the execute-stage
// ALU. A request (mult_signal or div_signal) is taken only while idle. The unit
// then works one bit per clock on operand magnitudes and applies the result sign
// at the end. The pipeline is held with stall until the result is ready.
//
// Multiply : radix-2 shift-add into a 2*DATA_WIDTH accumulator. The result is
//            the low word. The exception flag is set when the full signed
//            product does not fit in DATA_WIDTH bits.
// Divide   : restoring division. The quotient truncates toward zero and the
//            remainder is dropped. The exception flag is set on divide-by-zero
//            (result 0) and on MIN / -1 (result MIN).
//
// Optional build macro:
//   MULTDIV_EARLY_TERM_EN - a multiply finishes as soon as the multiplier bits
//                           not yet consumed are all zero.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   data_operandA  in   multiplicand / dividend (signed)
//   data_operandB  in   multiplier / divisor (signed)
//   mult_signal    in   multiply request (wins over div_signal)
//   div_signal     in   divide request
//   data_result    out  product low word or quotient, held until next completion
//   data_exception out  overflow / divide-by-zero of the last completed op
//   data_resultRDY out  one-cycle completion pulse
//   stall          out  pipeline freeze request
// -----------------------------------------------------------------------------
module multdiv_iterative_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  input  logic                  mult_signal,
  input  logic                  div_signal,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  stall
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0] counter;
  logic                 neg_result;
  logic                 div_zero;

  // multiply working registers
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [DW-1:0] mplier;

  // divide working registers
  logic [DW-1:0] mag_b;
  logic [DW-1:0] rem;
  logic [DW-1:0] quo;

  // combinational helpers
  logic [DW-1:0] abs_a, abs_b;
  logic          last_iter;
  logic          mult_finish;
  logic [PW-1:0] acc_step;
  logic [PW-1:0] prod_signed;
  logic          mult_exc;
  logic [DW:0]   rem_sh;
  logic [DW:0]   div_ext;
  logic          fits;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] quo_step;
  logic [DW-1:0] quo_signed;
  logic          div_exc;

  // Operand magnitudes and the arithmetic of one iteration. The final-value
  // logic looks at the values after the current iteration, so that the result
  // registers can be loaded on the same edge that enters DONE. The magnitude
  // of the most negative value stays correct when read as unsigned.
  always_comb begin
    abs_a = data_operandA[DW-1] ? -data_operandA : data_operandA;
    abs_b = data_operandB[DW-1] ? -data_operandB : data_operandB;

    last_iter = (counter == CNT_WIDTH'(DW - 1));

    acc_step    = acc + (mplier[0] ? mcand : '0);
    prod_signed = neg_result ? -acc_step : acc_step;
    mult_exc    = (prod_signed[PW-1:DW] != {DW{prod_signed[DW-1]}});

`ifdef MULTDIV_EARLY_TERM_EN
    mult_finish = last_iter || (mplier[DW-1:1] == '0);
`else
    mult_finish = last_iter;
`endif

    rem_sh     = {rem, quo[DW-1]};
    div_ext    = {1'b0, mag_b};
    fits       = (rem_sh >= div_ext);
    rem_step   = fits ? DW'(rem_sh - div_ext) : rem_sh[DW-1:0];
    quo_step   = {quo[DW-2:0], fits};
    quo_signed = neg_result ? -quo_step : quo_step;
    // A positive quotient with its top bit set can only come from MIN / -1.
    div_exc    = !neg_result && quo_step[DW-1];
  end

  // State register. An asynchronous reset drops any operation in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the handshake outputs. In IDLE, stall follows the
  // request inputs directly, so the pipeline freezes in the request cycle.
  // Reset masks stall because the raw request inputs may still be high then.
  always_comb begin
    state_next     = state;
    stall          = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      IDLE: begin
        stall = (mult_signal || div_signal) && !reset;
        if (mult_signal) begin
          state_next = MULT;
        end else if (div_signal) begin
          state_next = DIV;
        end
      end
      MULT: begin
        stall = 1'b1;
        if (mult_finish) begin
          state_next = DONE;
        end
      end
      DIV: begin
        stall = 1'b1;
        if (div_zero || last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. A request in IDLE latches the magnitudes and the result sign.
  // MULT and DIV advance one bit per edge. The result and exception registers
  // change only on the edge that moves into DONE, so they keep their values
  // between completions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter        <= '0;
      neg_result     <= 1'b0;
      div_zero       <= 1'b0;
      mcand          <= '0;
      acc            <= '0;
      mplier         <= '0;
      mag_b          <= '0;
      rem            <= '0;
      quo            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_signal || div_signal) begin
            counter    <= '0;
            neg_result <= data_operandA[DW-1] ^ data_operandB[DW-1];
            div_zero   <= !mult_signal && (data_operandB == '0);
            mcand      <= {{DW{1'b0}}, abs_a};
            acc        <= '0;
            mplier     <= abs_b;
            mag_b      <= abs_b;
            rem        <= '0;
            quo        <= abs_a;
          end
        end
        MULT: begin
          acc     <= acc_step;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CNT_WIDTH'(1);
          if (mult_finish) begin
            data_result    <= prod_signed[DW-1:0];
            data_exception <= mult_exc;
          end
        end
        DIV: begin
          if (div_zero) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end else begin
            rem     <= rem_step;
            quo     <= quo_step;
            counter <= counter + CNT_WIDTH'(1);
            if (last_iter) begin
              data_result    <= quo_signed;
              data_exception <= div_exc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iterative_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_iterative_unit
//
// Directed bench for multdiv_iterative_unit. Each request pushes a reference
// result (computed with native 64-bit signed arithmetic) onto a scoreboard
// queue. The entry is popped and compared when data_resultRDY pulses. The bench
// also checks the cycle of completion, how long stall stays high, the single-
// cycle RDY pulse, ignored requests and an asynchronous reset in mid-operation.
// Build with MULTDIV_EARLY_TERM_EN to match the early-terminating multiply.
// -----------------------------------------------------------------------------
module tb_multdiv_iterative_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        mult_signal;
  logic        div_signal;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   assertions;
  int   failures;

  multdiv_iterative_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .mult_signal    (mult_signal),
    .div_signal     (div_signal),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model built on native signed arithmetic.
  function automatic exp_t modelOp(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] p;
    logic signed [31:0] q;
    if (is_mult) begin
      p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      r.res = p[31:0];
      r.exc = (p[63:32] != {32{p[31]}});
    end else if (b == 32'd0) begin
      r.res = 32'd0;
      r.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.res = 32'h8000_0000;
      r.exc = 1'b1;
    end else begin
      q     = $signed(a) / $signed(b);
      r.res = q;
      r.exc = 1'b0;
    end
    return r;
  endfunction

  // Cycles from the accept cycle (cycle 0) to the RDY cycle.
  function automatic int expLatency(input bit is_mult, input logic [31:0] b);
    logic [31:0] mag;
    int          hi;
    if (!is_mult) begin
      return (b == 32'd0) ? 2 : 33;
    end
    mag = b[31] ? -b : b;
    hi  = 0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) hi = i;
    end
`ifdef MULTDIV_EARLY_TERM_EN
    return hi + 2;
`else
    return (hi >= 0) ? 33 : 0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present a request for one cycle and push its expected result. This task
  // returns at the falling edge of cycle 1, the first cycle after the accept.
  task automatic applyStimulus(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    mult_signal   = m;
    div_signal    = d;
    sb.push_back(modelOp(m, a, b));
    #1;
    checkOutput("stall_accept", {31'd0, stall}, 32'd1);
    @(negedge clock);
    mult_signal   = 1'b0;
    div_signal    = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait for RDY within a fixed budget. Then check the latency, the stall
  // duration, the scoreboard entry and the single-cycle pulse. A div_signal
  // pulse is injected in cycle inject_div (0 means no injection).
  task automatic waitResult(input string tag, input int exp_lat, input int exp_stall, input int inject_div);
    int   cycles;
    int   stall_cnt;
    exp_t e;
    cycles    = 1;
    stall_cnt = 0;
    while (cycles <= 100) begin
      div_signal = (cycles == inject_div);
      #1;
      if (data_resultRDY) break;
      if (stall) stall_cnt++;
      @(negedge clock);
      cycles++;
    end
    div_signal = 1'b0;
    checkOutput({tag, "_latency"}, cycles, exp_lat);
    if (exp_stall >= 0) checkOutput({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    checkOutput({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_result"}, data_result, e.res);
      checkOutput({tag, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
    end else begin
      checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end
    @(negedge clock);
    #1;
    checkOutput({tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  // Apply one operation and check it against the model and the expected timing.
  task automatic runOp(input string tag, input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input bit zero_div);
    int lat;
    lat = expLatency(m, b);
    applyStimulus(m, d, a, b);
    waitResult(tag, lat, zero_div ? -1 : lat - 1, 0);
  endtask

  initial begin
    int   rdy_seen;
    logic [31:0] ra, rb;
    assertions    = 0;
    failures      = 0;
    reset         = 1'b1;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    mult_signal   = 1'b0;
    div_signal    = 1'b0;

    #12;
    checkOutput("reset_result", data_result, 32'd0);
    checkOutput("reset_exception", {31'd0, data_exception}, 32'd0);
    checkOutput("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] directed multiply and divide");
    runOp("mul_7_m6", 1'b1, 1'b0, 32'd7, -32'sd6, 1'b0);
    runOp("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    runOp("mul_m1_min", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    runOp("div_m100_7", 1'b0, 1'b1, -32'sd100, 32'd7, 1'b0);
    runOp("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runOp("div_by_zero", 1'b0, 1'b1, 32'd55, 32'd0, 1'b1);

    $display("[TB] simultaneous request and ignored div pulse");
    applyStimulus(1'b1, 1'b1, 32'd9, 32'd3);
    waitResult("both_9_3", expLatency(1'b1, 32'd3), expLatency(1'b1, 32'd3) - 1, 2);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    checkOutput("no_second_rdy", rdy_seen, 32'd0);

    $display("[TB] asynchronous reset during divide");
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_result", data_result, 32'd0);
    checkOutput("midreset_exception", {31'd0, data_exception}, 32'd0);
    checkOutput("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    checkOutput("midreset_stall", {31'd0, stall}, 32'd0);
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b0;
    runOp("mul_after_reset", 1'b1, 1'b0, 32'd2, 32'd3, 1'b0);

    $display("[TB] random operands");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      runOp("rand_mul", 1'b1, 1'b0, ra, rb, 1'b0);
      ra = $urandom;
      rb = (i[0]) ? -32'($urandom_range(1, 50)) : 32'($urandom_range(1, 100000));
      runOp("rand_div", 1'b0, 1'b1, ra, rb, 1'b0);
    end

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
